// File: rtl/main_memory_responder.sv
// Main-memory responder: word-addressed backing RAM serving one read or write at a time
// with a fixed access latency. Optional macro MAIN_MEMORY_STATS_EN adds completed-read and
// completed-write counters.
module main_memory_responder #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned LATENCY        = 3
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iReadReq,
  input  logic                  iWriteReq,
  input  logic [31:0]           iAddress,
  input  logic [DATA_WIDTH-1:0] iWriteData,
  input  logic [3:0]            iByteEn,
  input  logic                  iAbort,
  output logic                  oReady,
  output logic                  oDataValid,
  output logic [DATA_WIDTH-1:0] oData,
`ifdef MAIN_MEMORY_STATS_EN
  output logic [31:0]           oReadCount,
  output logic [31:0]           oWriteCount,
`endif
  output logic                  oWriteAck
);

  localparam int unsigned Depth   = 2 ** MEM_ADDR_WIDTH;
  localparam logic [3:0]  LatInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic                      is_wr_q, is_wr_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]     mem_q [Depth];

  logic access;
  logic unused_addr;

  // Address bits outside the word index are deliberately ignored (aliasing).
  assign unused_addr = ^{iAddress[31:MEM_ADDR_WIDTH+2], iAddress[1:0]};

  // An access fires on the last WAIT edge unless aborted at that same edge.
  assign access = (state_q == StWait) && !iAbort && (cnt_q == 4'd0);

  // Next-state logic: accept in IDLE, count down in WAIT, single response cycle in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (iWriteReq || iReadReq) begin
          // Write wins a tie; the read stays held by the requester.
          is_wr_d = iWriteReq;
          idx_d   = iAddress[MEM_ADDR_WIDTH+1:2];
          wdata_d = iWriteData;
          be_d    = iByteEn;
          cnt_d   = LatInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (iAbort) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
          if (!is_wr_q) rdata_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and transaction registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= 4'd0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Backing RAM write, byte-lane masked; contents survive reset.
  always_ff @(posedge iCLK) begin
    if (!iRST && access && is_wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

`ifdef MAIN_MEMORY_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Counters advance on the edge that enters RESP, so aborted transactions never count.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (access && !is_wr_q) rd_cnt_d = rd_cnt_q + 32'd1;
    if (access && is_wr_q)  wr_cnt_d = wr_cnt_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign oReadCount  = rd_cnt_q;
  assign oWriteCount = wr_cnt_q;
`endif

  assign oReady     = (state_q == StIdle);
  assign oDataValid = (state_q == StResp) && !is_wr_q;
  assign oWriteAck  = (state_q == StResp) && is_wr_q;
  assign oData      = rdata_q;

endmodule
